xmit_frame_scheduler: RTL and testbench
=======================================

# xmit_frame_scheduler

Frame-level scheduler for the transmit path. It sits between the high- and low-priority control/data FIFOs and the PHY serializer. Each frame it picks one queue and pops that queue's control entry. It then streams the frame's bytes out under serializer backpressure, or drains malformed frames with `m_discard_en`, and enforces an inter-frame gap. Arbitration is strict priority with a starvation guard for the low queue.

## Interface
- `LEN_W`, 12: width of the frame-length field (control word bits [11:0]).
- `MIN_LEN`, 64: smallest legal frame, in bytes.
- `MAX_LEN`, 1518: largest legal frame, in bytes.
- `IFG_CYCLES`, 12: idle cycles after each transmitted frame.
- `HI_BURST_MAX`, 4: maximum consecutive high grants while the low queue is waiting.

- `clk_sys` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `hi_ctrl_valid` in 1: head of high control FIFO is present.
- `hi_ctrl_len` in LEN_W: head frame length, high queue.
- `lo_ctrl_valid` in 1: head of low control FIFO is present.
- `lo_ctrl_len` in LEN_W: head frame length, low queue.
- `tx_ready` in 1: serializer accepts a byte this cycle.
- `hi_ctrl_pop` out 1: one-cycle pop pulse, high control FIFO.
- `lo_ctrl_pop` out 1: one-cycle pop pulse, low control FIFO.
- `hi_data_rd` out 1: read enable, high data FIFO.
- `lo_data_rd` out 1: read enable, low data FIFO.
- `tx_sel` out 1: data mux select (0 = high, 1 = low); held for the whole frame.
- `tx_byte_valid` out 1: byte on the mux is presented to the serializer.
- `tx_sof` out 1: first byte of frame.
- `tx_eof` out 1: last byte of frame.
- `m_discard_en` out 1: high while a malformed frame is being drained.
- `busy` out 1: state ≠ IDLE.

## Operation
States and transitions:
- IDLE:
  - Grant high if `hi_ctrl_valid && (!lo_ctrl_valid || hi_streak < HI_BURST_MAX)`; otherwise grant low if `lo_ctrl_valid`.
  - On a grant: pulse the matching `*_ctrl_pop`, latch `len` and `tx_sel`, clear the byte counter.
  - Next state is DISCARD if `len < MIN_LEN || len > MAX_LEN`, else XFER.
- XFER:
  - In each cycle with `tx_ready`: selected `*_data_rd` = 1, `tx_byte_valid` = 1, counter increments.
  - `tx_sof` on counter = 0; `tx_eof` on counter = len−1.
  - After the eof byte, go to GAP.
- DISCARD:
  - `m_discard_en` = 1 for max(len,1) cycles.
  - Selected `*_data_rd` = 1 while counter < len, regardless of `tx_ready`.
  - `tx_byte_valid`, `tx_sof`, `tx_eof` stay 0.
  - Then go to IDLE; no gap.
- GAP: IFG_CYCLES cycles with no activity, then IDLE.

Starvation guard:
- `hi_streak` saturates at HI_BURST_MAX.
- It increments on a high grant made while `lo_ctrl_valid` = 1.
- It clears on a low grant, and on a high grant made while `lo_ctrl_valid` = 0.
- Discards count as grants.

Arithmetic and widths:
- Byte counter and gap counter are LEN_W bits; the counter never wraps within a frame.
- len = 0 is a discard lasting one cycle, with zero reads.

## Timing
- Reset values: every output 0, state IDLE, `hi_streak` 0, `tx_sel` 0.
- Reset mid-frame: the frame is aborted, no eof is emitted, and the already-popped control entry is lost. The FIFOs are flushed by the same reset.
- Pop and grant decision happen in the same IDLE cycle T. The first data read is no earlier than T+1.
- `*_data_rd` and `tx_byte_valid` are combinational from the state register and `tx_ready`. The upstream FIFO is show-ahead, so the byte is valid in the same cycle.
- Minimum frame-to-frame spacing:
  - After a transmitted frame: eof cycle + IFG_CYCLES + 1 (the next IDLE decision cycle).
  - After a discard: last discard cycle + 1.
- Control valid that arrives while busy is ignored until IDLE. Simultaneous valid on both queues is resolved by the IDLE rule only.
- Pop is never issued without the corresponding valid.

## Structure
- Package `xmit_sched_pkg`:
  - state enum {IDLE, XFER, DISCARD, GAP};
  - default parameter constants;
  - queue-select constants Q_HI = 0, Q_LO = 1.
- One natural sub-module: `xmit_sched_cnt`, a loadable LEN_W up/down counter. It is instanced twice: byte count, and gap count.
- Everything else lives in one FSM module.

## Test plan
- High frame with len 64, `tx_ready` = 1, pop at T:
  - reads at T+1..T+64;
  - `tx_sof` at T+1, `tx_eof` at T+64;
  - GAP T+65..T+76; next grant possible at T+77.
- Both queues continuously valid with len 64 → grant order hi, hi, hi, hi, lo, hi, hi, hi, hi, lo.
- High frame with len 32:
  - `m_discard_en` high for 32 cycles, with 32 `hi_data_rd`;
  - `tx_byte_valid` never asserts;
  - next IDLE immediately after, no gap.
- len 1519 → discard of 1519 cycles; len 0 → discard of 1 cycle with zero reads.
- len 64 with `tx_ready` toggling every cycle:
  - exactly 64 reads, each coincident with `tx_ready`;
  - eof on the 64th read;
  - `tx_sel` stable throughout.
- Assert `reset` after 10 bytes of a frame:
  - all outputs 0 from the reset edge;
  - state IDLE, `hi_streak` 0;
  - after reset deasserts, the next valid is granted normally.

Source files
------------

// File: rtl/xmit_sched_pkg.sv
// Shared types, defaults and helpers for the transmit frame scheduler.
package xmit_sched_pkg;

   localparam int DEF_LEN_W        = 12;
   localparam int DEF_MIN_LEN      = 64;
   localparam int DEF_MAX_LEN      = 1518;
   localparam int DEF_IFG_CYCLES   = 12;
   localparam int DEF_HI_BURST_MAX = 4;

   localparam logic Q_HI = 1'b0;
   localparam logic Q_LO = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_XFER    = 2'd1,
      ST_DISCARD = 2'd2,
      ST_GAP     = 2'd3
   } state_t;

   function automatic logic len_malformed(input int len, input int min_len, input int max_len);
      return (len < min_len) || (len > max_len);
   endfunction

endpackage

// File: rtl/xmit_sched_cnt.sv
// Loadable up/down counter; load wins over inc, inc wins over dec.
module xmit_sched_cnt #(
   parameter int W = 12
) (
   input  logic         clk_sys,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)     cnt_d = load_val;
      else if (inc) cnt_d = cnt_q + W'(1);
      else if (dec) cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/xmit_frame_scheduler.sv
// Per-frame strict-priority scheduler with low-queue starvation guard,
// serializer backpressure, malformed-frame drain and inter-frame gap.
module xmit_frame_scheduler
   import xmit_sched_pkg::*;
#(
   parameter int LEN_W        = DEF_LEN_W,
   parameter int MIN_LEN      = DEF_MIN_LEN,
   parameter int MAX_LEN      = DEF_MAX_LEN,
   parameter int IFG_CYCLES   = DEF_IFG_CYCLES,
   parameter int HI_BURST_MAX = DEF_HI_BURST_MAX
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             hi_ctrl_valid,
   input  logic [LEN_W-1:0] hi_ctrl_len,
   input  logic             lo_ctrl_valid,
   input  logic [LEN_W-1:0] lo_ctrl_len,
   input  logic             tx_ready,
   output logic             hi_ctrl_pop,
   output logic             lo_ctrl_pop,
   output logic             hi_data_rd,
   output logic             lo_data_rd,
   output logic             tx_sel,
   output logic             tx_byte_valid,
   output logic             tx_sof,
   output logic             tx_eof,
   output logic             m_discard_en,
   output logic             busy
);

   localparam int STREAK_W = $clog2(HI_BURST_MAX + 1);

   state_t              state_q, state_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic                sel_q, sel_d;
   logic [STREAK_W-1:0] hi_streak_q, hi_streak_d;
   logic [LEN_W-1:0]    byte_cnt, gap_cnt;
   logic [LEN_W:0]      byte_cnt_p1;
   logic                grant_hi, grant_lo, data_rd;
   logic                byte_load, byte_inc, gap_load, gap_dec;

   xmit_sched_cnt #(.W(LEN_W)) u_byte_cnt (
      .clk_sys (clk_sys), .reset (reset), .load (byte_load), .load_val ('0),
      .inc (byte_inc), .dec (1'b0), .cnt (byte_cnt)
   );

   xmit_sched_cnt #(.W(LEN_W)) u_gap_cnt (
      .clk_sys (clk_sys), .reset (reset), .load (gap_load), .load_val (LEN_W'(IFG_CYCLES)),
      .inc (1'b0), .dec (gap_dec), .cnt (gap_cnt)
   );

   // One extra bit so the drain-done compare is safe at len = 0.
   assign byte_cnt_p1 = {1'b0, byte_cnt} + {{LEN_W{1'b0}}, 1'b1};

   // Gated by reset so no pop escapes while the FIFOs are being flushed.
   always_comb begin
      grant_hi = 1'b0;
      grant_lo = 1'b0;
      if (state_q == ST_IDLE && !reset) begin
         grant_hi = hi_ctrl_valid && (!lo_ctrl_valid || hi_streak_q < STREAK_W'(HI_BURST_MAX));
         grant_lo = !grant_hi && lo_ctrl_valid;
      end
   end

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      sel_d         = sel_q;
      hi_streak_d   = hi_streak_q;
      byte_load     = 1'b0;
      byte_inc      = 1'b0;
      gap_load      = 1'b0;
      gap_dec       = 1'b0;
      data_rd       = 1'b0;
      hi_ctrl_pop   = 1'b0;
      lo_ctrl_pop   = 1'b0;
      tx_byte_valid = 1'b0;
      tx_sof        = 1'b0;
      tx_eof        = 1'b0;
      m_discard_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_hi || grant_lo) begin
               hi_ctrl_pop = grant_hi;
               lo_ctrl_pop = grant_lo;
               len_d       = grant_hi ? hi_ctrl_len : lo_ctrl_len;
               sel_d       = grant_hi ? Q_HI : Q_LO;
               byte_load   = 1'b1;
               state_d     = len_malformed(int'(len_d), MIN_LEN, MAX_LEN) ? ST_DISCARD : ST_XFER;
               if (grant_hi && lo_ctrl_valid) begin
                  if (hi_streak_q != STREAK_W'(HI_BURST_MAX))
                     hi_streak_d = hi_streak_q + STREAK_W'(1);
               end else begin
                  hi_streak_d = '0;
               end
            end
         end
         ST_XFER: begin
            if (tx_ready) begin
               data_rd       = 1'b1;
               tx_byte_valid = 1'b1;
               byte_inc      = 1'b1;
               tx_sof        = (byte_cnt == '0);
               tx_eof        = (byte_cnt == len_q - LEN_W'(1));
               if (tx_eof) begin
                  gap_load = 1'b1;
                  state_d  = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
               end
            end
         end
         ST_DISCARD: begin
            m_discard_en = 1'b1;
            data_rd      = (byte_cnt < len_q);
            byte_inc     = 1'b1;
            if (byte_cnt_p1 >= {1'b0, len_q}) state_d = ST_IDLE;
         end
         ST_GAP: begin
            gap_dec = 1'b1;
            if (gap_cnt == LEN_W'(1)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign hi_data_rd = data_rd && (sel_q == Q_HI);
   assign lo_data_rd = data_rd && (sel_q == Q_LO);
   assign tx_sel     = sel_q;
   assign busy       = (state_q != ST_IDLE);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         sel_q       <= Q_HI;
         hi_streak_q <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         sel_q       <= sel_d;
         hi_streak_q <= hi_streak_d;
      end
   end

endmodule

// File: tb/tb_xmit_frame_scheduler.sv
// Directed bench for xmit_frame_scheduler: frame timing, backpressure,
// discards, arbitration order and mid-frame reset.
module tb_xmit_frame_scheduler;
   import xmit_sched_pkg::*;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        hi_ctrl_valid = 1'b0, lo_ctrl_valid = 1'b0, tx_ready = 1'b0;
   logic [11:0] hi_ctrl_len = '0, lo_ctrl_len = '0;
   logic        hi_ctrl_pop, lo_ctrl_pop, hi_data_rd, lo_data_rd, tx_sel;
   logic        tx_byte_valid, tx_sof, tx_eof, m_discard_en, busy;
   logic [9:0]  outs;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int popped, n_rd, n_other, n_valid, n_sof, sof_at, n_eof, eof_at, eof_rd;
      int n_disc, rd_noready, sel_bad, idle_at;
   } fstat_t;

   xmit_frame_scheduler dut (
      .clk_sys (clk_sys), .reset (reset),
      .hi_ctrl_valid (hi_ctrl_valid), .hi_ctrl_len (hi_ctrl_len),
      .lo_ctrl_valid (lo_ctrl_valid), .lo_ctrl_len (lo_ctrl_len),
      .tx_ready (tx_ready),
      .hi_ctrl_pop (hi_ctrl_pop), .lo_ctrl_pop (lo_ctrl_pop),
      .hi_data_rd (hi_data_rd), .lo_data_rd (lo_data_rd),
      .tx_sel (tx_sel), .tx_byte_valid (tx_byte_valid),
      .tx_sof (tx_sof), .tx_eof (tx_eof),
      .m_discard_en (m_discard_en), .busy (busy)
   );

   assign outs = {hi_ctrl_pop, lo_ctrl_pop, hi_data_rd, lo_data_rd, tx_sel,
                  tx_byte_valid, tx_sof, tx_eof, m_discard_en, busy};

   always #5 clk_sys = ~clk_sys;

   task automatic nxt();
      @(posedge clk_sys);
      #1;
   endtask

   // Offers one frame on one queue, then records what happens until IDLE.
   task automatic run_frame(input bit hi, input int len, input bit toggle, output fstat_t s);
      s = '{default: 0};
      hi_ctrl_valid = hi;
      lo_ctrl_valid = !hi;
      hi_ctrl_len   = 12'(len);
      lo_ctrl_len   = 12'(len);
      tx_ready      = 1'b1;
      @(negedge clk_sys);
      s.popped = hi ? int'(hi_ctrl_pop && !lo_ctrl_pop) : int'(lo_ctrl_pop && !hi_ctrl_pop);
      nxt();
      hi_ctrl_valid = 1'b0;
      lo_ctrl_valid = 1'b0;
      for (int c = 1; c <= 2000; c++) begin
         tx_ready = toggle ? c[0] : 1'b1;
         @(negedge clk_sys);
         if (!busy) begin
            s.idle_at = c;
            break;
         end
         if (hi ? hi_data_rd : lo_data_rd) begin
            s.n_rd++;
            if (!tx_ready && !m_discard_en) s.rd_noready++;
         end
         if (hi ? lo_data_rd : hi_data_rd) s.n_other++;
         if (tx_byte_valid) s.n_valid++;
         if (tx_sof) begin s.n_sof++; s.sof_at = c; end
         if (tx_eof) begin s.n_eof++; s.eof_at = c; s.eof_rd = s.n_rd; end
         if (m_discard_en) s.n_disc++;
         if (tx_sel !== (hi ? Q_HI : Q_LO)) s.sel_bad++;
         nxt();
      end
      nxt();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      hi_ctrl_valid = 1'b1;
      lo_ctrl_valid = 1'b1;
      hi_ctrl_len = 12'd64;
      repeat (3) nxt();
      n_checks++; if (outs !== 10'b0) begin n_fail++; $display("FAIL reset outputs: got %b want 0", outs); end
      n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL reset state: got %0d want 0", dut.state_q); end
      n_checks++; if (dut.hi_streak_q !== '0) begin n_fail++; $display("FAIL reset streak: got %0d want 0", dut.hi_streak_q); end
      hi_ctrl_valid = 1'b0;
      lo_ctrl_valid = 1'b0;
      reset = 1'b0;
      nxt();
   endtask

   task automatic test_hi_frame();
      fstat_t s;
      run_frame(1'b1, 64, 1'b0, s);
      n_checks++; if (s.popped !== 1) begin n_fail++; $display("FAIL hi64 pop: got %0d want 1", s.popped); end
      n_checks++; if (s.n_rd !== 64) begin n_fail++; $display("FAIL hi64 reads: got %0d want 64", s.n_rd); end
      n_checks++; if (s.n_other !== 0) begin n_fail++; $display("FAIL hi64 lo reads: got %0d want 0", s.n_other); end
      n_checks++; if (s.n_valid !== 64) begin n_fail++; $display("FAIL hi64 valid: got %0d want 64", s.n_valid); end
      n_checks++; if (s.n_sof !== 1 || s.sof_at !== 1) begin n_fail++; $display("FAIL hi64 sof: got %0d@%0d want 1@1", s.n_sof, s.sof_at); end
      n_checks++; if (s.n_eof !== 1 || s.eof_at !== 64) begin n_fail++; $display("FAIL hi64 eof: got %0d@%0d want 1@64", s.n_eof, s.eof_at); end
      n_checks++; if (s.n_disc !== 0) begin n_fail++; $display("FAIL hi64 discard: got %0d want 0", s.n_disc); end
      n_checks++; if (s.idle_at !== 77) begin n_fail++; $display("FAIL hi64 next idle: got %0d want 77", s.idle_at); end
   endtask

   task automatic test_lo_frame();
      fstat_t s;
      run_frame(1'b0, 64, 1'b0, s);
      n_checks++; if (s.popped !== 1) begin n_fail++; $display("FAIL lo64 pop: got %0d want 1", s.popped); end
      n_checks++; if (s.n_rd !== 64 || s.n_other !== 0) begin n_fail++; $display("FAIL lo64 reads: got %0d/%0d want 64/0", s.n_rd, s.n_other); end
      n_checks++; if (s.sel_bad !== 0) begin n_fail++; $display("FAIL lo64 sel: got %0d bad cycles want 0", s.sel_bad); end
      n_checks++; if (s.idle_at !== 77) begin n_fail++; $display("FAIL lo64 next idle: got %0d want 77", s.idle_at); end
   endtask

   task automatic test_backpressure();
      fstat_t s;
      run_frame(1'b1, 64, 1'b1, s);
      n_checks++; if (s.n_rd !== 64) begin n_fail++; $display("FAIL bp reads: got %0d want 64", s.n_rd); end
      n_checks++; if (s.rd_noready !== 0) begin n_fail++; $display("FAIL bp read without ready: got %0d want 0", s.rd_noready); end
      n_checks++; if (s.eof_rd !== 64 || s.eof_at !== 127) begin n_fail++; $display("FAIL bp eof: got read %0d@%0d want 64@127", s.eof_rd, s.eof_at); end
      n_checks++; if (s.sel_bad !== 0) begin n_fail++; $display("FAIL bp sel: got %0d bad cycles want 0", s.sel_bad); end
      n_checks++; if (s.idle_at !== 140) begin n_fail++; $display("FAIL bp next idle: got %0d want 140", s.idle_at); end
   endtask

   task automatic test_discard();
      fstat_t s;
      run_frame(1'b1, 32, 1'b1, s);
      n_checks++; if (s.n_disc !== 32 || s.n_rd !== 32) begin n_fail++; $display("FAIL disc32: got disc %0d rd %0d want 32/32", s.n_disc, s.n_rd); end
      n_checks++; if (s.n_valid + s.n_sof + s.n_eof !== 0) begin n_fail++; $display("FAIL disc32 tx strobes: got %0d want 0", s.n_valid + s.n_sof + s.n_eof); end
      n_checks++; if (s.idle_at !== 33) begin n_fail++; $display("FAIL disc32 next idle: got %0d want 33", s.idle_at); end
      run_frame(1'b1, 63, 1'b0, s);
      n_checks++; if (s.n_disc !== 63 || s.idle_at !== 64) begin n_fail++; $display("FAIL disc63: got disc %0d idle %0d want 63/64", s.n_disc, s.idle_at); end
      run_frame(1'b1, 1519, 1'b0, s);
      n_checks++; if (s.n_disc !== 1519 || s.n_rd !== 1519) begin n_fail++; $display("FAIL disc1519: got disc %0d rd %0d want 1519/1519", s.n_disc, s.n_rd); end
      n_checks++; if (s.idle_at !== 1520) begin n_fail++; $display("FAIL disc1519 next idle: got %0d want 1520", s.idle_at); end
      run_frame(1'b0, 0, 1'b0, s);
      n_checks++; if (s.n_disc !== 1 || s.n_rd !== 0) begin n_fail++; $display("FAIL disc0: got disc %0d rd %0d want 1/0", s.n_disc, s.n_rd); end
      n_checks++; if (s.idle_at !== 2) begin n_fail++; $display("FAIL disc0 next idle: got %0d want 2", s.idle_at); end
      run_frame(1'b1, 1518, 1'b0, s);
      n_checks++; if (s.n_disc !== 0 || s.n_rd !== 1518 || s.eof_at !== 1518) begin n_fail++; $display("FAIL max1518: got disc %0d rd %0d eof@%0d want 0/1518/1518", s.n_disc, s.n_rd, s.eof_at); end
      n_checks++; if (s.idle_at !== 1531) begin n_fail++; $display("FAIL max1518 next idle: got %0d want 1531", s.idle_at); end
   endtask

   task automatic test_arbitration();
      logic [9:0] order = '0;
      int at[10];
      int got = 0, both = 0;
      reset = 1'b1;
      nxt();
      reset = 1'b0;
      hi_ctrl_valid = 1'b1;
      lo_ctrl_valid = 1'b1;
      hi_ctrl_len = 12'd64;
      lo_ctrl_len = 12'd64;
      tx_ready = 1'b1;
      for (int c = 0; c < 1000 && got < 10; c++) begin
         @(negedge clk_sys);
         if (hi_ctrl_pop && lo_ctrl_pop) both++;
         else if (hi_ctrl_pop || lo_ctrl_pop) begin
            order[got] = lo_ctrl_pop;
            at[got] = c;
            got++;
         end
         nxt();
      end
      hi_ctrl_valid = 1'b0;
      lo_ctrl_valid = 1'b0;
      n_checks++; if (got !== 10) begin n_fail++; $display("FAIL arb grants: got %0d want 10", got); end
      n_checks++; if (order !== 10'h210) begin n_fail++; $display("FAIL arb order (bit=lo): got %b want 1000010000", order); end
      n_checks++; if (both !== 0) begin n_fail++; $display("FAIL arb double pop: got %0d want 0", both); end
      n_checks++; if (got == 10 && at[9] - at[0] !== 693) begin n_fail++; $display("FAIL arb spacing: got %0d want 693", at[9] - at[0]); end
      for (int c = 0; c < 200; c++) begin
         @(negedge clk_sys);
         if (!busy) break;
         nxt();
      end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arb drain: got busy %b want 0", busy); end
      nxt();
   endtask

   task automatic test_reset_mid_frame();
      fstat_t s;
      int eofs = 0;
      hi_ctrl_valid = 1'b1;
      lo_ctrl_valid = 1'b1;
      hi_ctrl_len = 12'd64;
      tx_ready = 1'b1;
      @(negedge clk_sys);
      n_checks++; if (hi_ctrl_pop !== 1'b1) begin n_fail++; $display("FAIL rstmid pop: got %b want 1", hi_ctrl_pop); end
      nxt();
      hi_ctrl_valid = 1'b0;
      lo_ctrl_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_sys);
         if (tx_eof) eofs++;
         nxt();
      end
      n_checks++; if (dut.hi_streak_q !== 3'd1) begin n_fail++; $display("FAIL rstmid streak before: got %0d want 1", dut.hi_streak_q); end
      hi_ctrl_valid = 1'b1;
      reset = 1'b1;
      #1;
      n_checks++; if (outs !== 10'b0) begin n_fail++; $display("FAIL rstmid outputs: got %b want 0", outs); end
      n_checks++; if (dut.state_q !== ST_IDLE || dut.hi_streak_q !== '0) begin n_fail++; $display("FAIL rstmid state/streak: got %0d/%0d want 0/0", dut.state_q, dut.hi_streak_q); end
      @(negedge clk_sys);
      if (tx_eof) eofs++;
      n_checks++; if (eofs !== 0) begin n_fail++; $display("FAIL rstmid eof: got %0d want 0", eofs); end
      nxt();
      reset = 1'b0;
      run_frame(1'b1, 64, 1'b0, s);
      n_checks++; if (s.popped !== 1 || s.n_rd !== 64) begin n_fail++; $display("FAIL rstmid regrant: got pop %0d rd %0d want 1/64", s.popped, s.n_rd); end
      n_checks++; if (s.sof_at !== 1 || s.eof_at !== 64 || s.idle_at !== 77) begin n_fail++; $display("FAIL rstmid timing: got sof %0d eof %0d idle %0d want 1/64/77", s.sof_at, s.eof_at, s.idle_at); end
   endtask

   initial begin
      test_reset();
      test_hi_frame();
      test_lo_frame();
      test_backpressure();
      test_discard();
      test_arbitration();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
